// File: rtl/alu_op_sequencer.sv
// Command-queue controller for the Select ALU: buffers {sel,a,b,chain} ops in a FIFO,
// issues them one at a time, captures each result and returns it over valid/ready.
module alu_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SELW  = 4,
    parameter int unsigned CNTW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SELW-1:0] cmd_sel,
    input  logic [W-1:0]    cmd_a,
    input  logic [W-1:0]    cmd_b,
    input  logic            cmd_chain,
    output logic [SELW-1:0] alu_sel,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_x,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [W-1:0]    res_data,
    output logic [SELW-1:0] res_sel,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SELW-1:0] sel_mem_q   [DEPTH];
    logic [W-1:0]    a_mem_q     [DEPTH];
    logic [W-1:0]    b_mem_q     [DEPTH];
    logic            chain_mem_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [SELW-1:0] alu_sel_q, alu_sel_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic            res_valid_q, res_valid_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic [SELW-1:0] res_sel_q, res_sel_d;
    logic [W-1:0]    last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic empty, full, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = cmd_valid && !full;

    // Next-state, pop decision and datapath updates.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                res_data_d  = alu_x;
                last_d      = alu_x;
                res_sel_d   = alu_sel_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNTW'(1);
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // last_q already holds the result being handed off when popping from HOLD.
        if (pop) begin
            alu_sel_d = sel_mem_q[rd_ptr_q[AW-1:0]];
            alu_a_d   = chain_mem_q[rd_ptr_q[AW-1:0]] ? last_q : a_mem_q[rd_ptr_q[AW-1:0]];
            alu_b_d   = b_mem_q[rd_ptr_q[AW-1:0]];
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem_q[wr_ptr_q[AW-1:0]]   <= cmd_sel;
            a_mem_q[wr_ptr_q[AW-1:0]]     <= cmd_a;
            b_mem_q[wr_ptr_q[AW-1:0]]     <= cmd_b;
            chain_mem_q[wr_ptr_q[AW-1:0]] <= cmd_chain;
        end
    end

    assign cmd_ready = !full;
    assign busy      = (state_q != IDLE) || !empty;
    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sel   = res_sel_q;
    assign op_count  = cnt_q;

endmodule
